// File: rtl/vram_arbiter.sv
// Video RAM arbiter: scanout fetch has absolute priority, CPU and debug bridge share
// the remaining slots round-robin. Optional CPU stall counter under VRAM_ARB_STATS_EN.
module vram_arbiter #(
  parameter int unsigned AWIDTH = 11,
  parameter int unsigned DWIDTH = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  // Scanout fetch
  input  logic              vga_req_i,
  input  logic [AWIDTH-1:0] vga_addr_i,
  output logic [DWIDTH-1:0] vga_rdata_o,
  output logic              vga_rvalid_o,
  // CPU data bus
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [AWIDTH-1:0] cpu_addr_i,
  input  logic [DWIDTH-1:0] cpu_wdata_i,
  output logic [DWIDTH-1:0] cpu_rdata_o,
  output logic              cpu_ack_o,
  // SPI debug bridge
  input  logic              dbg_req_i,
  input  logic              dbg_we_i,
  input  logic [AWIDTH-1:0] dbg_addr_i,
  input  logic [DWIDTH-1:0] dbg_wdata_i,
  output logic [DWIDTH-1:0] dbg_rdata_o,
  output logic              dbg_ack_o,
  // RAM port
  output logic [AWIDTH-1:0] mem_addr_o,
  output logic [DWIDTH-1:0] mem_wdata_o,
  output logic              mem_we_o,
  input  logic [DWIDTH-1:0] mem_rdata_i,
  // Statistics
  output logic [15:0]       stall_count_o,
  input  logic              stall_clr_i
);

  typedef enum logic [1:0] {
    PendNone,
    PendVga,
    PendCpu,
    PendDbg
  } pend_e;

  pend_e             pend_q, pend_d;
  logic              rr_dbg_q, rr_dbg_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [DWIDTH-1:0] wdata_q, wdata_d;
  logic              cpu_elig, dbg_elig;
  logic              pick_cpu;

  // A requester whose completion is still pending is not eligible, so a held request
  // is never serviced twice.
  always_comb begin
    pend_d   = PendNone;
    rr_dbg_d = rr_dbg_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    mem_we_o = 1'b0;
    cpu_elig = cpu_req_i && (pend_q != PendCpu);
    dbg_elig = dbg_req_i && (pend_q != PendDbg);
    pick_cpu = cpu_elig && (!dbg_elig || !rr_dbg_q);

    if (!reset_i) begin
      if (vga_req_i) begin
        pend_d = PendVga;
        addr_d = vga_addr_i;
      end else if (pick_cpu) begin
        pend_d   = PendCpu;
        addr_d   = cpu_addr_i;
        wdata_d  = cpu_wdata_i;
        mem_we_o = cpu_we_i;
        rr_dbg_d = 1'b1;
      end else if (dbg_elig) begin
        pend_d   = PendDbg;
        addr_d   = dbg_addr_i;
        wdata_d  = dbg_wdata_i;
        mem_we_o = dbg_we_i;
        rr_dbg_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pend_q   <= PendNone;
      rr_dbg_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      pend_q   <= pend_d;
      rr_dbg_q <= rr_dbg_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  // Idle cycles keep presenting the last address; reset forces the bus to zero.
  assign mem_addr_o  = reset_i ? '0 : addr_d;
  assign mem_wdata_o = reset_i ? '0 : wdata_d;

  // Completions are masked during reset so an interrupted access is dropped.
  assign vga_rvalid_o = (pend_q == PendVga) && !reset_i;
  assign cpu_ack_o    = (pend_q == PendCpu) && !reset_i;
  assign dbg_ack_o    = (pend_q == PendDbg) && !reset_i;

  assign vga_rdata_o = vga_rvalid_o ? mem_rdata_i : '0;
  assign cpu_rdata_o = cpu_ack_o    ? mem_rdata_i : '0;
  assign dbg_rdata_o = dbg_ack_o    ? mem_rdata_i : '0;

`ifdef VRAM_ARB_STATS_EN
  logic [15:0] stall_q, stall_d;

  // Counts cycles the CPU waits with no grant and no completion outstanding.
  always_comb begin
    stall_d = stall_q;
    if (stall_clr_i) begin
      stall_d = '0;
    end else if (cpu_req_i && (pend_d != PendCpu) && (pend_q != PendCpu) &&
                 (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_count_o = stall_q;
`else
  logic unused_stall_clr;
  assign unused_stall_clr = stall_clr_i;
  assign stall_count_o    = 16'h0000;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: directed scenarios plus random traffic checked
// every cycle against a transaction-level model with its own shadow memory.
module tb_vram_arbiter;
  localparam int unsigned AW = 11;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          vga_req, vga_rvalid;
  logic [AW-1:0] vga_addr;
  logic [DW-1:0] vga_rdata;
  logic          cpu_req, cpu_we, cpu_ack;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          dbg_req, dbg_we, dbg_ack;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata, dbg_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_we;
  logic [15:0]   stall_count;
  logic          stall_clr;

  initial forever #5 clk = ~clk;

  vram_arbiter #(.AWIDTH(AW), .DWIDTH(DW)) dut (
    .clk_i(clk), .reset_i(reset),
    .vga_req_i(vga_req), .vga_addr_i(vga_addr), .vga_rdata_o(vga_rdata),
    .vga_rvalid_o(vga_rvalid),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr),
    .cpu_wdata_i(cpu_wdata), .cpu_rdata_o(cpu_rdata), .cpu_ack_o(cpu_ack),
    .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr),
    .dbg_wdata_i(dbg_wdata), .dbg_rdata_o(dbg_rdata), .dbg_ack_o(dbg_ack),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_we_o(mem_we),
    .mem_rdata_i(mem_rdata),
    .stall_count_o(stall_count), .stall_clr_i(stall_clr)
  );

  // Environment RAM driven by the DUT, registered read.
  logic [DW-1:0] ram     [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  bit            m_vga_pend, m_cpu_pend, m_dbg_pend, m_cpu_rd, m_dbg_rd;
  logic [DW-1:0] m_vga_data, m_cpu_data, m_dbg_data;
  logic [AW-1:0] m_last_addr = '0;
  bit            m_turn_dbg;
  int unsigned   m_stall;
  bit            cpu_done, dbg_done;

  always @(negedge clk) begin
    int who;
    if (reset) begin
      check("rst_vga_rvalid", 32'(vga_rvalid), 0);
      check("rst_cpu_ack", 32'(cpu_ack), 0);
      check("rst_dbg_ack", 32'(dbg_ack), 0);
      check("rst_vga_rdata", 32'(vga_rdata), 0);
      check("rst_cpu_rdata", 32'(cpu_rdata), 0);
      check("rst_dbg_rdata", 32'(dbg_rdata), 0);
      check("rst_mem_we", 32'(mem_we), 0);
      check("rst_mem_addr", 32'(mem_addr), 0);
      check("rst_mem_wdata", 32'(mem_wdata), 0);
      m_vga_pend = 0; m_cpu_pend = 0; m_dbg_pend = 0;
      m_last_addr = '0; m_turn_dbg = 0; m_stall = 0;
      cpu_done = 0; dbg_done = 0;
    end else begin
      check("vga_rvalid", 32'(vga_rvalid), 32'(m_vga_pend));
      if (m_vga_pend) check("vga_rdata", 32'(vga_rdata), 32'(m_vga_data));
      check("cpu_ack", 32'(cpu_ack), 32'(m_cpu_pend));
      if (m_cpu_pend && m_cpu_rd) check("cpu_rdata", 32'(cpu_rdata), 32'(m_cpu_data));
      check("dbg_ack", 32'(dbg_ack), 32'(m_dbg_pend));
      if (m_dbg_pend && m_dbg_rd) check("dbg_rdata", 32'(dbg_rdata), 32'(m_dbg_data));
      check("stall_count", 32'(stall_count), m_stall);
      cpu_done = m_cpu_pend;
      dbg_done = m_dbg_pend;

      // who: 0 idle, 1 scanout, 2 cpu, 3 debug
      who = 0;
      if (vga_req) who = 1;
      else if (cpu_req && !m_cpu_pend && dbg_req && !m_dbg_pend) who = m_turn_dbg ? 3 : 2;
      else if (cpu_req && !m_cpu_pend) who = 2;
      else if (dbg_req && !m_dbg_pend) who = 3;

`ifdef VRAM_ARB_STATS_EN
      if (stall_clr) m_stall = 0;
      else if (cpu_req && who != 2 && !m_cpu_pend && m_stall < 65535) m_stall++;
`endif

      m_vga_pend = (who == 1);
      m_cpu_pend = (who == 2);
      m_dbg_pend = (who == 3);
      case (who)
        1: begin
          check("vga_mem_addr", 32'(mem_addr), 32'(vga_addr));
          check("vga_mem_we", 32'(mem_we), 0);
          m_vga_data  = ref_mem[vga_addr];
          m_last_addr = vga_addr;
        end
        2: begin
          check("cpu_mem_addr", 32'(mem_addr), 32'(cpu_addr));
          check("cpu_mem_we", 32'(mem_we), 32'(cpu_we));
          if (cpu_we) check("cpu_mem_wdata", 32'(mem_wdata), 32'(cpu_wdata));
          m_cpu_data = ref_mem[cpu_addr];
          m_cpu_rd   = !cpu_we;
          if (cpu_we) ref_mem[cpu_addr] = cpu_wdata;
          m_last_addr = cpu_addr;
          m_turn_dbg  = 1;
        end
        3: begin
          check("dbg_mem_addr", 32'(mem_addr), 32'(dbg_addr));
          check("dbg_mem_we", 32'(mem_we), 32'(dbg_we));
          if (dbg_we) check("dbg_mem_wdata", 32'(mem_wdata), 32'(dbg_wdata));
          m_dbg_data = ref_mem[dbg_addr];
          m_dbg_rd   = !dbg_we;
          if (dbg_we) ref_mem[dbg_addr] = dbg_wdata;
          m_last_addr = dbg_addr;
          m_turn_dbg  = 0;
        end
        default: begin
          check("idle_mem_we", 32'(mem_we), 0);
          check("idle_mem_addr", 32'(mem_addr), 32'(m_last_addr));
        end
      endcase
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_xfer(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          output logic [DW-1:0] rd, output int lat);
    cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = d; lat = 0;
    forever begin
      @(negedge clk);
      if (cpu_ack || lat >= 50) break;
      step();
      lat++;
    end
    rd = cpu_rdata;
    step();
    cpu_req = 0;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 3) != 0) return AW'($urandom_range(0, 15));
    return AW'($urandom_range(0, (1 << AW) - 1));
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] rd;
    int            lat, rv;
    bit            we_seen, ack_seen;

    reset = 1; stall_clr = 0;
    vga_req = 0; vga_addr = '0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
    for (int i = 0; i < (1 << AW); i++) begin
      rd = DW'($urandom);
      ram[i] = rd;
      ref_mem[i] = rd;
    end
    ram[11'h010] = 16'hBEEF;
    ref_mem[11'h010] = 16'hBEEF;
    step(); step();
    reset = 0;

    // Scanout read
    vga_req = 1; vga_addr = 11'h010;
    step();
    vga_req = 0;
    @(negedge clk);
    check("t1_rvalid", 32'(vga_rvalid), 1);
    check("t1_rdata", 32'(vga_rdata), 32'h0000BEEF);
    step();

    // CPU write then read back
    cpu_xfer(1, 11'h123, 16'hA5A5, rd, lat);
    check("t2_wr_latency", 32'(lat), 1);
    cpu_xfer(0, 11'h123, 16'h0000, rd, lat);
    check("t2_rd_latency", 32'(lat), 1);
    check("t2_rd_data", 32'(rd), 32'h0000A5A5);

    // Scanout burst blocks a held CPU write
    cpu_req = 1; cpu_we = 1; cpu_addr = 11'h200; cpu_wdata = 16'h1234;
    rv = 0; we_seen = 0; ack_seen = 0;
    for (int i = 0; i < 4; i++) begin
      vga_req = 1; vga_addr = AW'(i + 'h300);
      @(negedge clk);
      rv += int'(vga_rvalid); we_seen |= mem_we; ack_seen |= cpu_ack;
      step();
    end
    vga_req = 0;
    @(negedge clk);
    rv += int'(vga_rvalid); ack_seen |= cpu_ack;
    check("t3_cpu_grant_we", 32'(mem_we), 1);
    step();
    @(negedge clk);
    check("t3_cpu_ack", 32'(cpu_ack), 1);
    step();
    cpu_req = 0;
    check("t3_rvalid_count", 32'(rv), 4);
    check("t3_we_in_vga_slot", 32'(we_seen), 0);
    check("t3_early_ack", 32'(ack_seen), 0);
`ifndef VRAM_ARB_STATS_EN
    check("t3_stall_off", 32'(stall_count), 0);
`endif

    // Round-robin alternation from reset
    reset = 1;
    step();
    reset = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 11'h005;
    dbg_req = 1; dbg_we = 0; dbg_addr = 11'h006;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check("t4_cpu_ack", 32'(cpu_ack), 32'(i % 2 == 1));
      check("t4_dbg_ack", 32'(dbg_ack), 32'(i % 2 == 0 && i > 0));
      step();
    end
    cpu_req = 0; dbg_req = 0;
    step(); step();

    // Reset right after a CPU grant drops the completion
    cpu_req = 1; cpu_we = 1; cpu_addr = 11'h050; cpu_wdata = 16'h7777;
    step();
    reset = 1;
    @(negedge clk);
    check("t5_no_ack_in_reset", 32'(cpu_ack), 0);
    check("t5_mem_we", 32'(mem_we), 0);
    check("t5_mem_addr", 32'(mem_addr), 0);
    step();
    reset = 0; cpu_req = 0;
    @(negedge clk);
    check("t5_no_late_ack", 32'(cpu_ack), 0);
    check("t5_stall_zero", 32'(stall_count), 0);
    step();

`ifdef VRAM_ARB_STATS_EN
    // Stall counting, clear and saturation
    cpu_req = 1; cpu_we = 0; cpu_addr = 11'h007;
    for (int i = 0; i < 5; i++) begin
      vga_req = 1; vga_addr = AW'(i);
      step();
    end
    vga_req = 0;
    @(negedge clk);
    check("t6_stall_5", 32'(stall_count), 5);
    step(); step();
    cpu_req = 0; stall_clr = 1;
    step();
    stall_clr = 0;
    @(negedge clk);
    check("t6_stall_clr", 32'(stall_count), 0);
    step();
    cpu_req = 1; vga_req = 1;
    for (int i = 0; i < 65540; i++) step();
    @(negedge clk);
    check("t6_stall_sat", 32'(stall_count), 32'h0000FFFF);
    step();
    stall_clr = 1;
    step();
    stall_clr = 0;
    @(negedge clk);
    check("t6_clr_wins", 32'(stall_count), 0);
    step();
    vga_req = 0;
    step(); step();
    cpu_req = 0;
    step();
`else
    stall_clr = 1;
    step();
    stall_clr = 0;
    cpu_req = 1; vga_req = 1;
    step(); step();
    @(negedge clk);
    check("t6_stall_tied", 32'(stall_count), 0);
    step();
    vga_req = 0;
    step(); step();
    cpu_req = 0;
    step();
`endif

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      if (reset || cpu_done) cpu_req = 0;
      if (reset || dbg_done) dbg_req = 0;
      reset = ($urandom_range(0, 399) == 0);
      vga_req = ($urandom_range(0, 9) < 3);
      vga_addr = rand_addr();
      if (!cpu_req && $urandom_range(0, 2) == 0) begin
        cpu_req = 1; cpu_we = 1'($urandom_range(0, 1));
        cpu_addr = rand_addr(); cpu_wdata = DW'($urandom);
      end
      if (!dbg_req && $urandom_range(0, 2) == 0) begin
        dbg_req = 1; dbg_we = 1'($urandom_range(0, 1));
        dbg_addr = rand_addr(); dbg_wdata = DW'($urandom);
      end
      stall_clr = ($urandom_range(0, 49) == 0);
      step();
    end
    reset = 0; vga_req = 0; cpu_req = 0; dbg_req = 0; stall_clr = 0;
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
